// File: rtl/pc_fetch_unit_if.sv
// Fetch-unit bus: redirect/stall controls, instruction-memory handshake and IF/ID outputs.
// master = fetch unit, slave = surrounding core / memory side.
interface pc_fetch_unit_if;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_rdy;
    logic [15:0] imem_data;
    logic        if_valid;
    logic [15:0] if_instr;
    logic [15:0] if_pc;
    logic [15:0] if_pc_plus2;
    logic        halted;

    modport master (
        input  stall, redirect, redirect_pc, imem_rdy, imem_data,
        output imem_req, imem_addr, if_valid, if_instr, if_pc, if_pc_plus2, halted
    );

    modport slave (
        output stall, redirect, redirect_pc, imem_rdy, imem_data,
        input  imem_req, imem_addr, if_valid, if_instr, if_pc, if_pc_plus2, halted
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// PC register and fetch sequencer: one outstanding imem request, one-entry skid buffer,
// redirect flush with in-flight response discard, and HLT detection.
module pc_fetch_unit #(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
    input  logic              clk,
    input  logic              rst_n,
    pc_fetch_unit_if.master   bus
);
    typedef enum logic [1:0] {S_FETCH, S_WAIT, S_HALT} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_pc;
    logic        r_if_valid;
    logic [15:0] r_if_instr;
    logic [15:0] r_if_pc;
    logic [15:0] r_if_pc_plus2;
    logic        r_halted;
    logic        r_skid_valid;
    logic [15:0] r_skid_instr;
    logic [15:0] r_skid_pc;
    logic        r_discard;

    logic        w_req;
    logic        w_accept;
    logic        w_ifid_ready;
    logic        w_outstanding;
    logic        w_is_hlt;
    logic [15:0] w_pc_plus2;

    always_comb begin
        w_state_nxt   = r_state;
        w_outstanding = (r_state == S_WAIT) || r_discard;
        w_ifid_ready  = !bus.stall || !r_if_valid;
        w_pc_plus2    = r_pc + 16'd2;
        w_is_hlt      = (bus.imem_data[15:12] == HALT_OPCODE);
        w_accept      = (r_state == S_WAIT) && bus.imem_rdy && !r_discard && !bus.redirect;
        // A full skid buffer may drain and be replaced by a new request in the same cycle.
        w_req         = (r_state == S_FETCH) && !bus.redirect && !r_discard &&
                        (!r_skid_valid || w_ifid_ready);

        if (bus.redirect) begin
            w_state_nxt = S_FETCH;
        end else begin
            case (r_state)
                S_FETCH: if (w_req) w_state_nxt = S_WAIT;
                S_WAIT:  if (bus.imem_rdy) w_state_nxt = w_is_hlt ? S_HALT : S_FETCH;
                S_HALT:  w_state_nxt = S_HALT;
                default: w_state_nxt = S_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_FETCH;
            r_pc          <= RESET_PC;
            r_if_valid    <= 1'b0;
            r_if_instr    <= '0;
            r_if_pc       <= '0;
            r_if_pc_plus2 <= '0;
            r_halted      <= 1'b0;
            r_skid_valid  <= 1'b0;
            r_skid_instr  <= '0;
            r_skid_pc     <= '0;
            r_discard     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (bus.redirect) begin
                r_pc         <= {bus.redirect_pc[15:1], 1'b0};
                r_if_valid   <= 1'b0;
                r_skid_valid <= 1'b0;
                r_halted     <= 1'b0;
                // A response arriving in the redirect cycle is itself the dropped one.
                r_discard    <= w_outstanding && !bus.imem_rdy;
            end else begin
                if (r_discard && bus.imem_rdy) r_discard <= 1'b0;
                if (w_accept) begin
                    r_pc <= w_pc_plus2;
                    if (w_is_hlt) r_halted <= 1'b1;
                end
                if (w_ifid_ready) begin
                    if (r_skid_valid) begin
                        r_if_valid    <= 1'b1;
                        r_if_instr    <= r_skid_instr;
                        r_if_pc       <= r_skid_pc;
                        r_if_pc_plus2 <= r_skid_pc + 16'd2;
                        r_skid_valid  <= 1'b0;
                    end else if (w_accept) begin
                        r_if_valid    <= 1'b1;
                        r_if_instr    <= bus.imem_data;
                        r_if_pc       <= r_pc;
                        r_if_pc_plus2 <= w_pc_plus2;
                    end else begin
                        r_if_valid    <= 1'b0;
                    end
                end else if (w_accept) begin
                    r_skid_valid <= 1'b1;
                    r_skid_instr <= bus.imem_data;
                    r_skid_pc    <= r_pc;
                end
            end
        end
    end

    // Request is gated by reset so the bus is quiet the instant rst_n falls.
    assign bus.imem_req    = w_req && rst_n;
    assign bus.imem_addr   = r_pc;
    assign bus.if_valid    = r_if_valid;
    assign bus.if_instr    = r_if_instr;
    assign bus.if_pc       = r_if_pc;
    assign bus.if_pc_plus2 = r_if_pc_plus2;
    assign bus.halted      = r_halted;
endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: the bench plays the memory and the downstream stages
// cycle by cycle and checks hand-computed expectations with immediate assertions.
module tb_pc_fetch_unit;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    pc_fetch_unit_if bus ();

    pc_fetch_unit #(
        .RESET_PC    (16'h0000),
        .HALT_OPCODE (4'hF)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ifid(input string tag, input logic [15:0] instr,
                            input logic [15:0] pc, input logic [15:0] pc2);
        chk({tag, "_valid"}, {15'd0, bus.if_valid}, 16'd1);
        chk({tag, "_instr"}, bus.if_instr, instr);
        chk({tag, "_pc"}, bus.if_pc, pc);
        chk({tag, "_pc2"}, bus.if_pc_plus2, pc2);
    endtask

    task automatic chk_req(input string tag, input logic req, input logic [15:0] addr);
        chk({tag, "_req"}, {15'd0, bus.imem_req}, {15'd0, req});
        if (req) chk({tag, "_addr"}, bus.imem_addr, addr);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.stall = 1'b0;
        bus.redirect = 1'b0;
        bus.redirect_pc = 16'h0000;
        bus.imem_rdy = 1'b0;
        bus.imem_data = 16'h0000;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", {15'd0, bus.imem_req}, 16'd0);
        chk("rst_valid", {15'd0, bus.if_valid}, 16'd0);
        chk("rst_instr", bus.if_instr, 16'h0000);
        chk("rst_pc", bus.if_pc, 16'h0000);
        chk("rst_pc2", bus.if_pc_plus2, 16'h0000);
        chk("rst_halted", {15'd0, bus.halted}, 16'd0);
        chk("rst_addr", bus.imem_addr, 16'h0000);

        // Zero-wait fetch of two words
        rst_n = 1'b1;
        #1;
        chk_req("f0", 1'b1, 16'h0000);
        cyc();
        chk_req("f0_wait", 1'b0, 16'h0000);
        bus.imem_rdy = 1'b1; bus.imem_data = 16'h1234;
        cyc();
        bus.imem_rdy = 1'b0;
        #1;
        chk_ifid("w0", 16'h1234, 16'h0000, 16'h0002);
        chk_req("f1", 1'b1, 16'h0002);
        cyc();
        bus.imem_rdy = 1'b1; bus.imem_data = 16'h5678;
        cyc();
        bus.imem_rdy = 1'b0;
        bus.stall = 1'b1;
        #1;
        chk_ifid("w1", 16'h5678, 16'h0002, 16'h0004);
        chk_req("f2", 1'b1, 16'h0004);

        // Stall for 4 cycles while the response arrives into the skid buffer
        cyc();
        bus.imem_rdy = 1'b1; bus.imem_data = 16'hABCD;
        cyc();
        bus.imem_rdy = 1'b0;
        #1;
        chk_ifid("stall_a", 16'h5678, 16'h0002, 16'h0004);
        chk_req("stall_a", 1'b0, 16'h0000);
        cyc();
        chk_ifid("stall_b", 16'h5678, 16'h0002, 16'h0004);
        chk_req("stall_b", 1'b0, 16'h0000);
        cyc();
        bus.stall = 1'b0;
        #1;
        chk_req("drain_issue", 1'b1, 16'h0006);
        chk("drain_hold_instr", bus.if_instr, 16'h5678);
        cyc();
        chk_ifid("drain", 16'hABCD, 16'h0004, 16'h0006);
        cyc();
        chk("no_dup_valid", {15'd0, bus.if_valid}, 16'd0);
        bus.imem_rdy = 1'b1; bus.imem_data = 16'h1111;
        cyc();
        bus.imem_rdy = 1'b0;
        #1;
        chk_ifid("after_drain", 16'h1111, 16'h0006, 16'h0008);
        chk_req("f4", 1'b1, 16'h0008);

        // Redirect with a 3-cycle-latency request in flight, stalled IF/ID
        cyc();
        bus.stall = 1'b1;
        bus.redirect = 1'b1; bus.redirect_pc = 16'h0041;
        #1;
        chk_req("redir_cycle", 1'b0, 16'h0000);
        cyc();
        bus.redirect = 1'b0;
        bus.stall = 1'b0;
        #1;
        chk("redir_flush_valid", {15'd0, bus.if_valid}, 16'd0);
        chk_req("redir_discard_a", 1'b0, 16'h0000);
        cyc();
        bus.imem_rdy = 1'b1; bus.imem_data = 16'hDEAD;
        #1;
        chk_req("redir_discard_b", 1'b0, 16'h0000);
        cyc();
        bus.imem_rdy = 1'b0;
        #1;
        chk("redir_drop_valid", {15'd0, bus.if_valid}, 16'd0);
        chk("redir_drop_instr", bus.if_instr, 16'h1111);
        chk_req("redir_target", 1'b1, 16'h0040);
        cyc();
        bus.imem_rdy = 1'b1; bus.imem_data = 16'h2222;
        cyc();
        bus.imem_rdy = 1'b0;
        #1;
        chk_ifid("redir_word", 16'h2222, 16'h0040, 16'h0042);

        // HLT at 0x0010
        bus.redirect = 1'b1; bus.redirect_pc = 16'h0010;
        cyc();
        bus.redirect = 1'b0;
        #1;
        chk_req("hlt_fetch", 1'b1, 16'h0010);
        cyc();
        bus.imem_rdy = 1'b1; bus.imem_data = 16'hF000;
        cyc();
        bus.imem_rdy = 1'b0;
        #1;
        chk_ifid("hlt_word", 16'hF000, 16'h0010, 16'h0012);
        chk("hlt_halted", {15'd0, bus.halted}, 16'd1);
        for (int i = 0; i < 20; i++) begin
            chk_req("hlt_quiet", 1'b0, 16'h0000);
            cyc();
        end
        chk("hlt_pc", bus.imem_addr, 16'h0012);
        chk("hlt_still_halted", {15'd0, bus.halted}, 16'd1);
        bus.redirect = 1'b1; bus.redirect_pc = 16'h0100;
        cyc();
        bus.redirect = 1'b0;
        #1;
        chk("resume_halted", {15'd0, bus.halted}, 16'd0);
        chk_req("resume", 1'b1, 16'h0100);
        cyc();
        bus.imem_rdy = 1'b1; bus.imem_data = 16'h3333;
        cyc();
        bus.imem_rdy = 1'b0;
        #1;
        chk_ifid("resume_word", 16'h3333, 16'h0100, 16'h0102);

        // PC wrap at 0xFFFE
        bus.redirect = 1'b1; bus.redirect_pc = 16'hFFFE;
        cyc();
        bus.redirect = 1'b0;
        #1;
        chk_req("wrap_fetch", 1'b1, 16'hFFFE);
        cyc();
        bus.imem_rdy = 1'b1; bus.imem_data = 16'h4444;
        cyc();
        bus.imem_rdy = 1'b0;
        #1;
        chk_ifid("wrap_word", 16'h4444, 16'hFFFE, 16'h0000);
        chk_req("wrap_next", 1'b1, 16'h0000);

        // Reset pulsed mid-WAIT with IF/ID held by stall
        bus.stall = 1'b1;
        cyc();
        chk("pre_rst_valid", {15'd0, bus.if_valid}, 16'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {15'd0, bus.if_valid}, 16'd0);
        chk("mid_rst_instr", bus.if_instr, 16'h0000);
        chk("mid_rst_pc", bus.if_pc, 16'h0000);
        chk("mid_rst_pc2", bus.if_pc_plus2, 16'h0000);
        chk("mid_rst_halted", {15'd0, bus.halted}, 16'd0);
        chk("mid_rst_req", {15'd0, bus.imem_req}, 16'd0);
        bus.stall = 1'b0;
        bus.imem_rdy = 1'b1; bus.imem_data = 16'h5555;
        cyc();
        rst_n = 1'b1;
        #1;
        chk_req("post_rst", 1'b1, 16'h0000);
        cyc();
        bus.imem_rdy = 1'b0;
        #1;
        chk("stale_ignored", {15'd0, bus.if_valid}, 16'd0);
        bus.imem_rdy = 1'b1; bus.imem_data = 16'h6666;
        cyc();
        bus.imem_rdy = 1'b0;
        #1;
        chk_ifid("post_rst_word", 16'h6666, 16'h0000, 16'h0002);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
